// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : RV32I IF stage and IF/ID register with req/ack instruction fetch,
//             ID stall absorption and branch redirect. Optional misaligned
//             redirect trap enabled by IFETCH_MISALIGN_TRAP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pcSrc,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
`ifdef IFETCH_MISALIGN_TRAP_EN
    S_HALT  = 2'd3,
`endif
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_started;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pend, w_pend_nxt;
  logic [31:0] r_hold, w_hold_nxt;
  logic [31:0] r_if_instr, w_if_instr_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic [31:0] w_target;
  logic        w_ack;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_err, w_err_nxt;
  logic w_trap;
  assign w_target     = branch_target;
  assign w_trap       = pcSrc & (branch_target[1:0] != 2'b00);
  assign misalign_err = r_err;
`else
  logic w_unused_tgt_lsb;
  assign w_target         = {branch_target[31:2], 2'b00};
  assign w_unused_tgt_lsb = ^branch_target[1:0];
  assign misalign_err     = 1'b0;
`endif

  // r_started delays the first request by one cycle after reset and masks
  // acks that belong to a request abandoned by reset.
  assign imem_req  = r_started & ((r_state == S_FETCH) | (r_state == S_DRAIN));
  assign imem_addr = r_pc;
  assign w_ack     = imem_ack & imem_req;

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;
  assign opcode   = r_if_instr[6:0];
  assign func3    = r_if_instr[14:12];
  assign func7    = r_if_instr[30];

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_nxt     = r_pend;
    w_hold_nxt     = r_hold;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    w_if_valid_nxt = r_if_valid;
`ifdef IFETCH_MISALIGN_TRAP_EN
    w_err_nxt      = r_err;
`endif
    case (r_state)
      S_FETCH: begin
        if (pcSrc) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (w_trap) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_HALT;
          end else
`endif
          if (!imem_req || w_ack) begin
            w_pc_nxt = w_target;
          end else begin
            // Request in flight: keep the address until it completes.
            w_pend_nxt  = w_target;
            w_state_nxt = S_DRAIN;
          end
        end else if (w_ack) begin
          if (stall) begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end else begin
            w_if_instr_nxt = imem_rdata;
            w_if_pc_nxt    = r_pc;
            w_if_valid_nxt = 1'b1;
            w_pc_nxt       = r_pc + 32'd4;
          end
        end else if (!stall) begin
          // ID consumed its instruction and nothing arrived: insert a bubble.
          w_if_instr_nxt = NOP_INSTR;
          w_if_valid_nxt = 1'b0;
        end
      end
      S_HOLD: begin
        if (pcSrc) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (w_trap) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_HALT;
          end else
`endif
          begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_FETCH;
          end
        end else if (!stall) begin
          w_if_instr_nxt = r_hold;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b1;
          w_pc_nxt       = r_pc + 32'd4;
          w_state_nxt    = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (pcSrc) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (w_trap) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_HALT;
          end else
`endif
          begin
            w_pend_nxt = w_target;
            if (w_ack) begin
              w_pc_nxt    = w_target;
              w_state_nxt = S_FETCH;
            end
          end
        end else if (w_ack) begin
          w_pc_nxt    = r_pend;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
`ifndef IFETCH_MISALIGN_TRAP_EN
        w_state_nxt = S_FETCH;
`endif
      end
    endcase
    if (pcSrc || flush) begin
      w_if_instr_nxt = NOP_INSTR;
      w_if_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_started  <= 1'b0;
      r_pc       <= RESET_PC;
      r_pend     <= 32'd0;
      r_hold     <= 32'd0;
      r_if_instr <= NOP_INSTR;
      r_if_pc    <= 32'd0;
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_started  <= 1'b1;
      r_pc       <= w_pc_nxt;
      r_pend     <= w_pend_nxt;
      r_hold     <= w_hold_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_err_nxt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit: directed vector table,
//             multi-cycle corner sequences and randomized reference-model run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit c_trap_en = 1'b1;
`else
  localparam bit c_trap_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, pcSrc, flush, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, if_valid, func7, misalign_err;
  logic [31:0] imem_addr, if_pc, if_instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pcSrc(pcSrc), .flush(flush),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .opcode(opcode), .func3(func3),
    .func7(func7), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, ps, fl;
    logic [31:0] tgt;
    logic        ak;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit later.
  task automatic apply(input logic rst, st, ps, fl, input logic [31:0] tgt,
                       input logic ak, input logic [31:0] rd);
    reset = rst; stall = st; pcSrc = ps; flush = fl;
    branch_target = tgt; imem_ack = ak; imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, valid});
    check({tag, ".pc"},    if_pc, pc);
    check({tag, ".instr"}, if_instr, instr);
  endtask

  // Reference model: a fetch pointer, an optional parked word, an optional
  // pending redirect behind an in-flight request, and the IF/ID contents.
  logic [31:0] m_pc, m_pend, m_hold_word, m_ipc, m_instr;
  bit          m_started, m_holding, m_draining, m_halted, m_v, m_err;

  function automatic void m_reset();
    m_pc = 32'h0; m_pend = 32'h0; m_hold_word = 32'h0;
    m_ipc = 32'h0; m_instr = 32'h13; m_v = 0; m_err = 0;
    m_started = 0; m_holding = 0; m_draining = 0; m_halted = 0;
  endfunction

  function automatic void m_deliver(input logic [31:0] w);
    m_instr = w; m_ipc = m_pc; m_v = 1; m_pc = m_pc + 32'd4;
  endfunction

  function automatic bit m_req();
    return m_started && !m_holding && !m_halted;
  endfunction

  function automatic void m_step(input bit rst, st, ps, fl, input logic [31:0] tgt,
                                 input bit ak, input logic [31:0] rd);
    bit          acc, mis;
    logic [31:0] t;
    if (rst) begin
      m_reset();
      return;
    end
    acc = ak && m_req();
    mis = c_trap_en && (tgt[1:0] != 2'b00);
    t   = c_trap_en ? tgt : {tgt[31:2], 2'b00};
    if (m_halted) begin
    end else if (ps && mis) begin
      m_halted = 1; m_err = 1; m_holding = 0; m_draining = 0;
    end else if (ps) begin
      if (m_draining) begin
        m_pend = t;
        if (acc) begin m_pc = t; m_draining = 0; end
      end else if (m_holding) begin
        m_pc = t; m_holding = 0;
      end else if (!m_req() || acc) begin
        m_pc = t;
      end else begin
        m_pend = t; m_draining = 1;
      end
    end else if (m_draining) begin
      if (acc) begin m_pc = m_pend; m_draining = 0; end
    end else if (m_holding) begin
      if (!st) begin m_deliver(m_hold_word); m_holding = 0; end
    end else if (acc) begin
      if (st) begin m_hold_word = rd; m_holding = 1; end
      else m_deliver(rd);
    end else if (!st) begin
      m_instr = 32'h13; m_v = 0;
    end
    if (ps || fl) begin m_instr = 32'h13; m_v = 0; end
    m_started = 1;
  endfunction

  initial begin
    // rst st ps fl tgt ak rd | req addr valid if_pc instr
    tbl[0] = '{1,0,0,0,0,1,32'h0, 0,32'h0, 0,32'h0,32'h13};
    tbl[1] = '{0,0,0,0,0,1,32'h0, 1,32'h0, 0,32'h0,32'h13};
    tbl[2] = '{0,0,0,0,0,1,32'h0, 1,32'h4, 1,32'h0,32'h0};
    tbl[3] = '{0,0,0,0,0,1,32'h4, 1,32'h8, 1,32'h4,32'h4};
    tbl[4] = '{0,0,0,0,0,1,32'h8, 1,32'hC, 1,32'h8,32'h8};
    tbl[5] = '{0,0,0,0,0,0,32'h0, 1,32'hC, 0,32'h8,32'h13};
    tbl[6] = '{0,0,0,0,0,0,32'h0, 1,32'hC, 0,32'h8,32'h13};
    tbl[7] = '{0,0,0,0,0,0,32'h0, 1,32'hC, 0,32'h8,32'h13};
    tbl[8] = '{0,0,0,0,0,1,32'hC, 1,32'h10,1,32'hC,32'hC};

    reset = 1; stall = 0; pcSrc = 0; flush = 0;
    branch_target = 0; imem_ack = 0; imem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.err", {31'd0, misalign_err}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].rst, tbl[i].st, tbl[i].ps, tbl[i].fl, tbl[i].tgt, tbl[i].ak, tbl[i].rd);
      expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                 tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_instr);
    end

    // Stall at the ack of 0x10: word parked, IF/ID keeps 0x0C, no request.
    apply(0, 1, 0, 0, 0, 1, 32'h10);
    expect_out("stall0", 0, 32'h10, 1, 32'hC, 32'hC);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 0, 0, 32'h0);
      expect_out($sformatf("stall%0d", i + 1), 0, 32'h10, 1, 32'hC, 32'hC);
    end
    apply(0, 0, 0, 0, 0, 0, 32'h0);
    expect_out("release", 1, 32'h14, 1, 32'h10, 32'h10);

    // Redirect behind an in-flight request to 0x40 drains it first.
    apply(0, 0, 1, 1, 32'h40, 1, 32'h14);
    expect_out("jmp40", 1, 32'h40, 0, 32'h10, 32'h13);
    apply(0, 0, 1, 1, 32'h200, 0, 32'h0);
    expect_out("drain0", 1, 32'h40, 0, 32'h10, 32'h13);
    apply(0, 1, 0, 0, 32'h0, 0, 32'h0);
    expect_out("drain1", 1, 32'h40, 0, 32'h10, 32'h13);
    apply(0, 0, 0, 0, 32'h0, 1, 32'hDEADBEEF);
    expect_out("drained", 1, 32'h200, 0, 32'h10, 32'h13);
    apply(0, 0, 0, 0, 32'h0, 1, 32'h200);
    expect_out("tgt200", 1, 32'h204, 1, 32'h200, 32'h200);

    // PC wrap-around and field decode.
    apply(0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'h204);
    expect_out("jmpTop", 1, 32'hFFFF_FFFC, 0, 32'h200, 32'h13);
    apply(0, 0, 0, 0, 32'h0, 1, 32'h4000_5033);
    expect_out("wrap", 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h4000_5033);
    check("opcode", {25'd0, opcode}, 32'h33);
    check("func3",  {29'd0, func3},  32'h5);
    check("func7",  {31'd0, func7},  32'h1);

    // Misaligned redirect.
    apply(0, 0, 1, 1, 32'h102, 1, 32'h1);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("mis.err", {31'd0, misalign_err}, 32'd1);
    check("mis.req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 32'h0, 1, 32'h7);
      check("halt.req",   {31'd0, imem_req}, 32'd0);
      check("halt.valid", {31'd0, if_valid}, 32'd0);
      check("halt.err",   {31'd0, misalign_err}, 32'd1);
    end
`else
    expect_out("mis", 1, 32'h100, 0, 32'hFFFF_FFFC, 32'h13);
    check("mis.err", {31'd0, misalign_err}, 32'd0);
    apply(0, 0, 0, 0, 32'h0, 1, 32'h100);
    expect_out("at100", 1, 32'h104, 1, 32'h100, 32'h100);
`endif
    apply(1, 0, 0, 0, 32'h0, 0, 32'h0);
    expect_out("rst2", 0, 32'h0, 0, 32'h0, 32'h13);
    check("rst2.err", {31'd0, misalign_err}, 32'd0);

    // Randomized run against the reference model.
    m_reset();
    for (int c = 0; c < 2000; c++) begin
      bit          rst, st, ps, fl, ak;
      logic [31:0] tgt, rd;
      rst = ($urandom_range(0, 99) == 0);
      ps  = ($urandom_range(0, 7) == 0);
      fl  = ps | ($urandom_range(0, 31) == 0);
      st  = ($urandom_range(0, 3) == 0);
      ak  = ($urandom_range(0, 2) != 0);
      tgt = $urandom;
      if (c_trap_en && $urandom_range(0, 15) != 0) tgt[1:0] = 2'b00;
      rd  = $urandom;
      m_step(rst, st, ps, fl, tgt, ak, rd);
      apply(rst, st, ps, fl, tgt, ak, rd);
      check("rnd.req",   {31'd0, imem_req}, {31'd0, m_req()});
      check("rnd.addr",  imem_addr, m_pc);
      check("rnd.valid", {31'd0, if_valid}, {31'd0, m_v});
      check("rnd.pc",    if_pc, m_ipc);
      check("rnd.instr", if_instr, m_instr);
      check("rnd.opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
      check("rnd.func3", {29'd0, func3}, {29'd0, m_instr[14:12]});
      check("rnd.func7", {31'd0, func7}, {31'd0, m_instr[30]});
      check("rnd.err",   {31'd0, misalign_err}, {31'd0, m_err});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
